// File: rtl/sdram_port_arb_if.sv
// Requester/controller bus bundle for the sdram port arbiter.
// slave = arbiter view, master = requesters plus controller.
interface sdram_port_arb_if #(
    parameter int NREQ       = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [NREQ-1:0]                     req_valid;
    logic [NREQ-1:0]                     req_ready;
    logic [NREQ-1:0]                     req_we;
    logic [NREQ-1:0][ADDR_WIDTH-1:0]     req_addr;
    logic [NREQ-1:0][DATA_WIDTH-1:0]     req_wdata;
    logic [NREQ-1:0][DATA_WIDTH/8-1:0]   req_wstrb;
    logic [NREQ-1:0]                     rsp_valid;
    logic [DATA_WIDTH-1:0]               rsp_rdata;
    logic                                m_valid;
    logic                                m_ready;
    logic                                m_we;
    logic [ADDR_WIDTH-1:0]               m_addr;
    logic [DATA_WIDTH-1:0]               m_wdata;
    logic [DATA_WIDTH/8-1:0]             m_wstrb;
    logic                                m_rvalid;
    logic [DATA_WIDTH-1:0]               m_rdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
        input  m_ready, m_rvalid, m_rdata,
        output req_ready, rsp_valid, rsp_rdata,
        output m_valid, m_we, m_addr, m_wdata, m_wstrb
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb,
        output m_ready, m_rvalid, m_rdata,
        input  req_ready, rsp_valid, rsp_rdata,
        input  m_valid, m_we, m_addr, m_wdata, m_wstrb
    );
endinterface

// File: rtl/sdram_port_arb.sv
// Round-robin arbiter sharing one sdram_core command port.
// Read tags are queued in order to route returning data.
module sdram_port_arb #(
    parameter int NREQ       = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_OUT    = 4
) (
    input  logic              clk,
    input  logic              rstn,
    sdram_port_arb_if.slave   bus,
    output logic              busy,
    output logic              err
);
    localparam int GW = $clog2(NREQ);
    localparam int PW = $clog2(MAX_OUT);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                state_q, state_d;
    logic [GW-1:0]         g_q, g_d;
    logic [GW-1:0]         rr_q, rr_d;
    logic [GW-1:0]         fifo_q [MAX_OUT];
    logic [GW-1:0]         fifo_d [MAX_OUT];
    logic [PW-1:0]         wr_q, wr_d;
    logic [PW-1:0]         rd_q, rd_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [NREQ-1:0]       rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  err_q, err_d;

    logic [GW-1:0]         sel;
    logic                  found;
    int                    j;
    logic                  m_valid;
    logic                  accept;
    logic                  push;
    logic                  pop;
    logic                  empty;
    logic                  full;
    logic [GW-1:0]         head;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CW'(MAX_OUT));
    assign head  = fifo_q[rd_q];

    // Pick the first requesting index at or after the round-robin pointer.
    always_comb begin
        sel   = rr_q;
        found = 1'b0;
        j     = 0;
        for (int i = 0; i < NREQ; i++) begin
            j = int'(rr_q) + i;
            if (j >= NREQ) j = j - NREQ;
            if (!found && bus.req_valid[j]) begin
                found = 1'b1;
                sel   = GW'(j);
            end
        end
    end

    // Grant FSM: latch a winner, then hold it until the controller accepts.
    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        rr_d    = rr_q;
        m_valid = 1'b0;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|bus.req_valid) begin
                    g_d     = sel;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                m_valid = bus.req_valid[g_q]
                        & (bus.req_we[g_q] | !full);
                accept  = m_valid & bus.m_ready;
                if (accept) begin
                    state_d = IDLE;
                    if (int'(g_q) == NREQ - 1) rr_d = '0;
                    else                       rr_d = g_q + GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Tag FIFO update and registered read-data routing.
    always_comb begin
        push        = accept & ~bus.req_we[g_q];
        pop         = bus.m_rvalid & ~empty;
        fifo_d      = fifo_q;
        if (push) fifo_d[wr_q] = g_q;
        wr_d        = wr_q + PW'(push);
        rd_d        = rd_q + PW'(pop);
        cnt_d       = cnt_q + CW'(push) - CW'(pop);
        rsp_valid_d = pop ? (NREQ'(1) << head) : '0;
        rsp_rdata_d = pop ? bus.m_rdata : rsp_rdata_q;
        err_d       = err_q | (bus.m_rvalid & empty);
    end

    // State, pointer, FIFO and response registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            g_q         <= '0;
            rr_q        <= '0;
            fifo_q      <= '{default: '0};
            wr_q        <= '0;
            rd_q        <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            g_q         <= g_d;
            rr_q        <= rr_d;
            fifo_q      <= fifo_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            err_q       <= err_d;
        end
    end

    assign bus.m_valid   = m_valid;
    assign bus.m_we      = bus.req_we[g_q];
    assign bus.m_addr    = bus.req_addr[g_q];
    assign bus.m_wdata   = bus.req_wdata[g_q];
    assign bus.m_wstrb   = bus.req_wstrb[g_q];
    assign bus.req_ready = accept ? (NREQ'(1) << g_q) : '0;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign busy          = (state_q == GRANT) | ~empty;
    assign err           = err_q;
endmodule

// File: tb/tb_sdram_port_arb.sv
// Directed testbench for sdram_port_arb (NREQ=2, MAX_OUT=4).
// Inputs driven 1ns after posedge, outputs sampled 2ns after posedge.
module tb_sdram_port_arb;
    logic clk;
    logic rstn;
    logic busy;
    logic err;
    int   checks;
    int   errors;

    sdram_port_arb_if #(.NREQ(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    sdram_port_arb #(
        .NREQ(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUT(4)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus),
        .busy (busy),
        .err  (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        bus.req_valid = '0;
        bus.m_rvalid  = 1'b0;
        rstn = 1'b0;
        step;
        step;
        rstn = 1'b1;
    endtask

    task automatic send(input int i, input logic we,
                        input logic [31:0] addr, input logic [31:0] wd);
        logic got;
        got = 1'b0;
        bus.req_we[i]    = we;
        bus.req_addr[i]  = addr;
        bus.req_wdata[i] = wd;
        bus.req_wstrb[i] = 4'hF;
        bus.req_valid[i] = 1'b1;
        for (int n = 0; n < 20; n++) begin
            #1;
            got = bus.req_ready[i];
            step;
            if (got) break;
        end
        bus.req_valid[i] = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL send_timeout req=%0d got ready=0 want 1", i);
        end
    endtask

    task automatic test_reset;
        bus.req_valid = 2'b11;
        bus.req_we    = 2'b11;
        bus.req_addr[0]  = 32'hA0;
        bus.req_addr[1]  = 32'hB0;
        bus.req_wdata[0] = 32'h1;
        bus.req_wdata[1] = 32'h2;
        bus.req_wstrb[0] = 4'hF;
        bus.req_wstrb[1] = 4'hF;
        bus.m_ready  = 1'b0;
        bus.m_rvalid = 1'b0;
        bus.m_rdata  = '0;
        rstn = 1'b0;
        step;
        step;
        #1;
        checks += 6;
        if (bus.m_valid !== 1'b0) begin errors++;
            $display("FAIL rst_m_valid got %b want 0", bus.m_valid); end
        if (bus.req_ready !== 2'b00) begin errors++;
            $display("FAIL rst_req_ready got %b want 00", bus.req_ready); end
        if (bus.rsp_valid !== 2'b00) begin errors++;
            $display("FAIL rst_rsp_valid got %b want 00", bus.rsp_valid); end
        if (bus.rsp_rdata !== 32'h0) begin errors++;
            $display("FAIL rst_rsp_rdata got %h want 0", bus.rsp_rdata); end
        if (busy !== 1'b0) begin errors++;
            $display("FAIL rst_busy got %b want 0", busy); end
        if (err !== 1'b0) begin errors++;
            $display("FAIL rst_err got %b want 0", err); end
        rstn = 1'b1;
        #1;
        checks++;
        if (bus.m_valid !== 1'b0) begin errors++;
            $display("FAIL rel_m_valid_early got %b want 0", bus.m_valid); end
        step;
        #1;
        checks += 3;
        if (bus.m_valid !== 1'b1) begin errors++;
            $display("FAIL rel_m_valid got %b want 1", bus.m_valid); end
        if (bus.m_addr !== 32'hA0) begin errors++;
            $display("FAIL rel_m_addr got %h want a0", bus.m_addr); end
        if (bus.req_ready !== 2'b00) begin errors++;
            $display("FAIL rel_req_ready got %b want 00", bus.req_ready); end
        bus.req_valid = '0;
    endtask

    task automatic test_round_robin;
        logic [1:0]  prev;
        logic [1:0]  exp_rdy;
        logic [31:0] exp_wd;
        int n0, n1, ei;
        do_reset;
        bus.req_we       = 2'b11;
        bus.req_addr[0]  = 32'h1000;
        bus.req_addr[1]  = 32'h2000;
        bus.req_wdata[0] = 32'hD000_0000;
        bus.req_wdata[1] = 32'hD100_0000;
        bus.m_ready      = 1'b1;
        bus.req_valid    = 2'b11;
        prev = 2'b00;
        n0 = 0;
        n1 = 0;
        for (int c = 0; c < 8; c++) begin
            step;
            if (prev[0]) begin
                n0++;
                bus.req_wdata[0] = 32'hD000_0000 + 32'(n0);
            end
            if (prev[1]) begin
                n1++;
                bus.req_wdata[1] = 32'hD100_0000 + 32'(n1);
            end
            #1;
            ei = (c / 2) % 2;
            exp_rdy = (c % 2 == 0) ? (ei == 1 ? 2'b10 : 2'b01) : 2'b00;
            checks += 2;
            if (bus.req_ready !== exp_rdy) begin errors++;
                $display("FAIL rr_ready c=%0d got %b want %b",
                         c, bus.req_ready, exp_rdy); end
            if (bus.m_valid !== (c % 2 == 0)) begin errors++;
                $display("FAIL rr_m_valid c=%0d got %b", c, bus.m_valid); end
            if (c % 2 == 0) begin
                exp_wd = (ei == 1) ? 32'hD100_0000 + 32'(n1)
                                   : 32'hD000_0000 + 32'(n0);
                checks += 2;
                if (bus.m_addr !== (ei == 1 ? 32'h2000 : 32'h1000)) begin
                    errors++;
                    $display("FAIL rr_addr c=%0d got %h", c, bus.m_addr);
                end
                if (bus.m_wdata !== exp_wd) begin errors++;
                    $display("FAIL rr_wdata c=%0d got %h want %h",
                             c, bus.m_wdata, exp_wd); end
            end
            prev = bus.req_ready;
        end
        bus.req_valid = '0;
    endtask

    task automatic test_read_routing;
        do_reset;
        bus.m_ready = 1'b1;
        send(1, 1'b0, 32'h100, 32'h0);
        send(0, 1'b0, 32'h200, 32'h0);
        #1;
        checks++;
        if (busy !== 1'b1) begin errors++;
            $display("FAIL rd_busy got %b want 1", busy); end
        bus.m_rvalid = 1'b1;
        bus.m_rdata  = 32'hAAAA;
        step;
        bus.m_rvalid = 1'b0;
        #1;
        checks += 2;
        if (bus.rsp_valid !== 2'b10) begin errors++;
            $display("FAIL rd_rsp1 got %b want 10", bus.rsp_valid); end
        if (bus.rsp_rdata !== 32'hAAAA) begin errors++;
            $display("FAIL rd_data1 got %h want aaaa", bus.rsp_rdata); end
        bus.m_rvalid = 1'b1;
        bus.m_rdata  = 32'hBBBB;
        step;
        bus.m_rvalid = 1'b0;
        #1;
        checks += 2;
        if (bus.rsp_valid !== 2'b01) begin errors++;
            $display("FAIL rd_rsp0 got %b want 01", bus.rsp_valid); end
        if (bus.rsp_rdata !== 32'hBBBB) begin errors++;
            $display("FAIL rd_data0 got %h want bbbb", bus.rsp_rdata); end
        step;
        #1;
        checks += 4;
        if (bus.rsp_valid !== 2'b00) begin errors++;
            $display("FAIL rd_rsp_idle got %b want 00", bus.rsp_valid); end
        if (bus.rsp_rdata !== 32'hBBBB) begin errors++;
            $display("FAIL rd_hold got %h want bbbb", bus.rsp_rdata); end
        if (busy !== 1'b0) begin errors++;
            $display("FAIL rd_busy_end got %b want 0", busy); end
        if (err !== 1'b0) begin errors++;
            $display("FAIL rd_err got %b want 0", err); end
    endtask

    task automatic test_fifo_full;
        do_reset;
        bus.m_ready = 1'b1;
        send(0, 1'b0, 32'h40, 32'h0);
        send(1, 1'b0, 32'h44, 32'h0);
        send(0, 1'b0, 32'h48, 32'h0);
        send(1, 1'b0, 32'h4C, 32'h0);
        bus.req_we[0]    = 1'b0;
        bus.req_addr[0]  = 32'h50;
        bus.req_we[1]    = 1'b1;
        bus.req_addr[1]  = 32'h60;
        bus.req_wdata[1] = 32'h6666;
        bus.req_valid    = 2'b11;
        step;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks += 2;
            if (bus.m_valid !== 1'b0) begin errors++;
                $display("FAIL full_block k=%0d got %b want 0",
                         k, bus.m_valid); end
            if (bus.req_ready !== 2'b00) begin errors++;
                $display("FAIL full_ready k=%0d got %b want 00",
                         k, bus.req_ready); end
            step;
        end
        bus.m_rvalid = 1'b1;
        bus.m_rdata  = 32'h1111;
        #1;
        checks++;
        if (bus.m_valid !== 1'b0) begin errors++;
            $display("FAIL full_pop_cycle got %b want 0", bus.m_valid); end
        step;
        bus.m_rvalid = 1'b0;
        #1;
        checks += 4;
        if (bus.rsp_valid !== 2'b01) begin errors++;
            $display("FAIL full_rsp got %b want 01", bus.rsp_valid); end
        if (bus.rsp_rdata !== 32'h1111) begin errors++;
            $display("FAIL full_rdata got %h want 1111", bus.rsp_rdata); end
        if (bus.req_ready !== 2'b01) begin errors++;
            $display("FAIL full_accept got %b want 01", bus.req_ready); end
        if (bus.m_addr !== 32'h50) begin errors++;
            $display("FAIL full_addr got %h want 50", bus.m_addr); end
        step;
        bus.req_valid[0] = 1'b0;
        step;
        #1;
        checks += 3;
        if (bus.m_valid !== 1'b1) begin errors++;
            $display("FAIL full_wr_valid got %b want 1", bus.m_valid); end
        if (bus.m_we !== 1'b1) begin errors++;
            $display("FAIL full_wr_we got %b want 1", bus.m_we); end
        if (bus.req_ready !== 2'b10) begin errors++;
            $display("FAIL full_wr_ready got %b want 10", bus.req_ready); end
        step;
        bus.req_valid[1] = 1'b0;
    endtask

    task automatic test_push_pop_and_stray;
        logic [1:0] exp_v;
        bus.m_rvalid = 1'b1;
        bus.m_rdata  = 32'h2222;
        step;
        bus.m_rvalid = 1'b0;
        #1;
        checks++;
        if (bus.rsp_valid !== 2'b10) begin errors++;
            $display("FAIL pp_rsp_a got %b want 10", bus.rsp_valid); end
        bus.req_we[1]    = 1'b0;
        bus.req_addr[1]  = 32'h300;
        bus.req_valid[1] = 1'b1;
        step;
        bus.m_rvalid = 1'b1;
        bus.m_rdata  = 32'h3333;
        #1;
        checks++;
        if (bus.req_ready !== 2'b10) begin errors++;
            $display("FAIL pp_ready got %b want 10", bus.req_ready); end
        step;
        bus.m_rvalid     = 1'b0;
        bus.req_valid[1] = 1'b0;
        #1;
        checks += 2;
        if (bus.rsp_valid !== 2'b01) begin errors++;
            $display("FAIL pp_rsp_b got %b want 01", bus.rsp_valid); end
        if (bus.rsp_rdata !== 32'h3333) begin errors++;
            $display("FAIL pp_rdata got %h want 3333", bus.rsp_rdata); end
        for (int k = 0; k < 3; k++) begin
            bus.m_rvalid = 1'b1;
            bus.m_rdata  = 32'h4000 + 32'(k);
            step;
            bus.m_rvalid = 1'b0;
            #1;
            exp_v = (k == 1) ? 2'b01 : 2'b10;
            checks++;
            if (bus.rsp_valid !== exp_v) begin errors++;
                $display("FAIL pp_drain k=%0d got %b want %b",
                         k, bus.rsp_valid, exp_v); end
        end
        checks += 2;
        if (busy !== 1'b0) begin errors++;
            $display("FAIL pp_busy got %b want 0", busy); end
        if (err !== 1'b0) begin errors++;
            $display("FAIL pp_err_pre got %b want 0", err); end
        bus.m_rvalid = 1'b1;
        bus.m_rdata  = 32'h5555;
        step;
        bus.m_rvalid = 1'b0;
        #1;
        checks += 3;
        if (bus.rsp_valid !== 2'b00) begin errors++;
            $display("FAIL stray_rsp got %b want 00", bus.rsp_valid); end
        if (err !== 1'b1) begin errors++;
            $display("FAIL stray_err got %b want 1", err); end
        if (bus.rsp_rdata !== 32'h4002) begin errors++;
            $display("FAIL stray_hold got %h want 4002", bus.rsp_rdata); end
    endtask

    task automatic test_reset_outstanding;
        do_reset;
        bus.m_ready = 1'b1;
        send(0, 1'b0, 32'h10, 32'h0);
        send(1, 1'b0, 32'h14, 32'h0);
        send(0, 1'b0, 32'h18, 32'h0);
        #1;
        checks++;
        if (busy !== 1'b1) begin errors++;
            $display("FAIL ro_busy_pre got %b want 1", busy); end
        rstn = 1'b0;
        step;
        step;
        rstn = 1'b1;
        #1;
        checks += 2;
        if (busy !== 1'b0) begin errors++;
            $display("FAIL ro_busy got %b want 0", busy); end
        if (err !== 1'b0) begin errors++;
            $display("FAIL ro_err_pre got %b want 0", err); end
        for (int k = 0; k < 3; k++) begin
            bus.m_rvalid = 1'b1;
            bus.m_rdata  = 32'h7000 + 32'(k);
            step;
            bus.m_rvalid = 1'b0;
            #1;
            checks++;
            if (bus.rsp_valid !== 2'b00) begin errors++;
                $display("FAIL ro_rsp k=%0d got %b want 00",
                         k, bus.rsp_valid); end
        end
        checks += 2;
        if (err !== 1'b1) begin errors++;
            $display("FAIL ro_err got %b want 1", err); end
        if (busy !== 1'b0) begin errors++;
            $display("FAIL ro_busy_end got %b want 0", busy); end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rstn          = 1'b0;
        bus.req_valid = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_wstrb = '0;
        bus.m_ready   = 1'b0;
        bus.m_rvalid  = 1'b0;
        bus.m_rdata   = '0;
        #1;
        test_reset;
        test_round_robin;
        test_read_routing;
        test_fifo_full;
        test_push_pop_and_stray;
        test_reset_outstanding;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
